// File: rtl/tennis_match_controller.sv
// Tennis match sequencer sitting between the debounced buttons and the ball shift register.
// Generates the moveBall step tick (speeding up on each rally hit), gates serving,
// detects points when the ball leaves the court, keeps score and alternates the server.
// Ports:
//   CLK100MHZ, nRESET : clock and asynchronous active-low reset
//   toss, hit         : one-cycle button pulses
//   nL[7:0]           : ball register, negative-true one-hot, bit 7 = left end, 8'hFF = no ball
//   moveBall          : one-cycle ball step tick
//   serveEn           : toss may load the ball
//   scoreL, scoreR    : player scores
//   server            : 0 = left serves, 1 = right serves
//   gameOver, state   : match status
module tennis_match_controller #(
    parameter int unsigned TICK_BASE   = 33_554_431,
    parameter int unsigned TICK_DEC    = 2_097_152,
    parameter int unsigned TICK_MIN    = 8_388_607,
    parameter int unsigned PAUSE_STEPS = 6,
    parameter int unsigned WIN_SCORE   = 7
) (
    input  logic       CLK100MHZ,
    input  logic       nRESET,
    input  logic       toss,
    input  logic       hit,
    input  logic [7:0] nL,
    output logic       moveBall,
    output logic       serveEn,
    output logic [3:0] scoreL,
    output logic [3:0] scoreR,
    output logic       server,
    output logic       gameOver,
    output logic [2:0] state
);

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned LOC_W   = 3;
    localparam int unsigned PAUSE_W = $clog2(PAUSE_STEPS + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_RALLY    = 3'd2,
        ST_POINT    = 3'd3,
        ST_PAUSE    = 3'd4,
        ST_GAMEOVER = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     period_q, period_d;
    logic                 move_ball_q, move_ball_d;
    logic                 serve_en_q, serve_en_d;
    logic                 game_over_q, game_over_d;
    logic [SCORE_W-1:0]   score_l_q, score_l_d;
    logic [SCORE_W-1:0]   score_r_q, score_r_d;
    logic                 server_q, server_d;
    logic [PAUSE_W-1:0]   pause_cnt_q, pause_cnt_d;
    logic [LOC_W-1:0]     last_loc_q, last_loc_d;

    logic                 ball_present_c;
    logic                 ball_onehot_c;
    logic [LOC_W-1:0]     zero_idx_c;
    logic [CNT_W-1:0]     period_dec_c;
    logic [SCORE_W-1:0]   score_inc_c;

    // Ball position decode from the negative-true register
    always_comb begin
        ball_present_c = (nL != 8'hFF);
        ball_onehot_c  = $onehot(~nL);
        zero_idx_c     = '0;
        for (int i = 0; i < 8; i++) begin
            if (!nL[i]) begin
                zero_idx_c = LOC_W'(i);
            end
        end
    end

    // Free-running tick: the reload happens the cycle before moveBall, so a period
    // change never truncates the interval already in flight
    always_comb begin
        move_ball_d = (cnt_q == '0);
        cnt_d       = (cnt_q == '0) ? period_q : cnt_q - CNT_W'(1);
    end

    // Saturating speed-up, written to avoid unsigned underflow
    always_comb begin
        if ((period_q >= CNT_W'(TICK_DEC)) &&
            ((period_q - CNT_W'(TICK_DEC)) >= CNT_W'(TICK_MIN))) begin
            period_dec_c = period_q - CNT_W'(TICK_DEC);
        end else begin
            period_dec_c = CNT_W'(TICK_MIN);
        end
    end

    // Illegal (non-one-hot) patterns leave the last known location untouched
    always_comb begin
        last_loc_d = last_loc_q;
        if (move_ball_q && ball_present_c && ball_onehot_c) begin
            last_loc_d = zero_idx_c;
        end
    end

    // Match FSM next state and registered outputs
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        server_d    = server_q;
        pause_cnt_d = pause_cnt_q;
        score_inc_c = '0;

        unique case (state_q)
            ST_IDLE: begin
                state_d  = ST_SERVE;
                period_d = CNT_W'(TICK_BASE);
            end
            ST_SERVE: begin
                if (move_ball_q && ball_present_c) begin
                    state_d = ST_RALLY;
                end
            end
            ST_RALLY: begin
                if (hit) begin
                    period_d = period_dec_c;
                end
                if (move_ball_q && !ball_present_c) begin
                    state_d = ST_POINT;
                end
            end
            ST_POINT: begin
                server_d    = ~server_q;
                pause_cnt_d = '0;
                // Ball last seen at the left end means the left player missed
                if (last_loc_q == LOC_W'(7)) begin
                    score_inc_c = score_r_q + SCORE_W'(1);
                    score_r_d   = score_inc_c;
                end else begin
                    score_inc_c = score_l_q + SCORE_W'(1);
                    score_l_d   = score_inc_c;
                end
                state_d = (score_inc_c == SCORE_W'(WIN_SCORE)) ? ST_GAMEOVER : ST_PAUSE;
            end
            ST_PAUSE: begin
                if (move_ball_q) begin
                    pause_cnt_d = pause_cnt_q + PAUSE_W'(1);
                    if (pause_cnt_d == PAUSE_W'(PAUSE_STEPS)) begin
                        state_d  = ST_SERVE;
                        period_d = CNT_W'(TICK_BASE);
                    end
                end
            end
            ST_GAMEOVER: begin
                if (toss) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    server_d  = 1'b0;
                    state_d   = ST_SERVE;
                    period_d  = CNT_W'(TICK_BASE);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        serve_en_d  = (state_d == ST_SERVE);
        game_over_d = (state_d == ST_GAMEOVER);
    end

    // State and output registers
    always_ff @(posedge CLK100MHZ or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_W'(TICK_BASE);
            period_q    <= CNT_W'(TICK_BASE);
            move_ball_q <= 1'b0;
            serve_en_q  <= 1'b0;
            game_over_q <= 1'b0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            server_q    <= 1'b0;
            pause_cnt_q <= '0;
            last_loc_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            move_ball_q <= move_ball_d;
            serve_en_q  <= serve_en_d;
            game_over_q <= game_over_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            server_q    <= server_d;
            pause_cnt_q <= pause_cnt_d;
            last_loc_q  <= last_loc_d;
        end
    end

    assign moveBall = move_ball_q;
    assign serveEn  = serve_en_q;
    assign scoreL   = score_l_q;
    assign scoreR   = score_r_q;
    assign server   = server_q;
    assign gameOver = game_over_q;
    assign state    = state_q;

endmodule

// File: tb/tb_tennis_match_controller.sv
// Bench for tennis_match_controller with short tick periods. The bench plays the
// role of the ball register by driving nL directly. Expected tick intervals and
// point outcomes are queued when stimulus is driven and checked by a monitor.
module tb_tennis_match_controller;

    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_RALLY = 3'd2,
                           S_POINT = 3'd3, S_PAUSE = 3'd4, S_GAMEOVER = 3'd5;

    typedef struct {
        logic [3:0] sl;
        logic [3:0] sr;
        logic       srv;
        logic [2:0] st;
    } exp_t;

    logic       clk;
    logic       nRESET;
    logic       toss;
    logic       hit;
    logic [7:0] nL;
    logic       moveBall;
    logic       serveEn;
    logic [3:0] scoreL;
    logic [3:0] scoreR;
    logic       server;
    logic       gameOver;
    logic [2:0] state;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned last_cyc = 0;
    logic [2:0]  prev_st  = 3'd0;

    int unsigned ivl_q[$];
    exp_t        score_q[$];

    tennis_match_controller #(
        .TICK_BASE  (15),
        .TICK_DEC   (4),
        .TICK_MIN   (7),
        .PAUSE_STEPS(2),
        .WIN_SCORE  (3)
    ) dut (
        .CLK100MHZ(clk),
        .nRESET   (nRESET),
        .toss     (toss),
        .hit      (hit),
        .nL       (nL),
        .moveBall (moveBall),
        .serveEn  (serveEn),
        .scoreL   (scoreL),
        .scoreR   (scoreR),
        .server   (server),
        .gameOver (gameOver),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (moveBall) seen = 1'b1;
        end
        if (!seen) check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_state(input logic [2:0] s);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (state == s) seen = 1'b1;
            else step();
        end
        if (!seen) check("state_timeout", 32'(state), 32'(s));
    endtask

    task automatic pulse_toss();
        toss = 1'b1;
        step();
        toss = 1'b0;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        step();
        hit = 1'b0;
    endtask

    task automatic push_point(input logic [3:0] sl, input logic [3:0] sr,
                              input logic srv, input logic [2:0] st);
        exp_t e;
        e.sl = sl; e.sr = sr; e.srv = srv; e.st = st;
        score_q.push_back(e);
    endtask

    // From RALLY: show the ball at one end, then let it leave the court
    task automatic finish_point(input bit left_miss, input logic [3:0] sl,
                                input logic [3:0] sr, input logic srv, input logic [2:0] st);
        nL = left_miss ? 8'h7F : 8'hFE;
        wait_tick();
        step();
        nL = 8'hFF;
        push_point(sl, sr, srv, st);
        wait_tick();
        step();
        step();
    endtask

    // From SERVE: load a ball, enter RALLY, then finish the point
    task automatic play_point(input bit left_miss, input logic [3:0] sl,
                              input logic [3:0] sr, input logic srv, input logic [2:0] st);
        nL = 8'hFE;
        pulse_toss();
        wait_tick();
        step();
        check("serve_to_rally", 32'(state), 32'(S_RALLY));
        finish_point(left_miss, sl, sr, srv, st);
        if (st == S_PAUSE) wait_state(S_SERVE);
    endtask

    // Monitor: tick intervals and point outcomes, sampled just after the edge
    always begin
        exp_t        s;
        int unsigned e;
        @(posedge clk);
        #1;
        cyc++;
        if (!nRESET) begin
            prev_st = S_IDLE;
        end else begin
            if (moveBall) begin
                if (ivl_q.size() > 0) begin
                    e = ivl_q.pop_front();
                    check("tick_interval", cyc - last_cyc, e);
                end
                last_cyc = cyc;
            end
            if (prev_st == S_POINT) begin
                if (score_q.size() > 0) begin
                    s = score_q.pop_front();
                    check("point_scoreL", 32'(scoreL), 32'(s.sl));
                    check("point_scoreR", 32'(scoreR), 32'(s.sr));
                    check("point_server", 32'(server), 32'(s.srv));
                    check("point_next_state", 32'(state), 32'(s.st));
                end else begin
                    check("unexpected_point", 32'd1, 32'd0);
                end
            end
            prev_st = state;
        end
    end

    initial begin
        int unsigned speed_ivl [4] = '{16, 12, 8, 8};

        nRESET = 1'b0;
        toss   = 1'b0;
        hit    = 1'b0;
        nL     = 8'hFF;
        repeat (3) step();

        // Reset and first serve
        check("rst_outputs", 32'({state, moveBall, serveEn, scoreL, scoreR, server, gameOver}), 32'd0);
        nRESET = 1'b1;
        check("idle_after_release", 32'(state), 32'(S_IDLE));
        step();
        check("serve_state", 32'(state), 32'(S_SERVE));
        check("serve_en", 32'(serveEn), 32'd1);
        wait_tick();
        ivl_q.push_back(16);
        wait_tick();
        ivl_q.push_back(16);
        wait_tick();
        check("scores_zero", 32'({scoreL, scoreR}), 32'd0);

        // Speed-up across three rally hits, plus a toss ignored mid-rally
        step();
        nL = 8'hFE;
        pulse_toss();
        ivl_q.push_back(16);
        wait_tick();
        for (int i = 0; i < 4; i++) begin
            ivl_q.push_back(speed_ivl[i]);
            if (i < 3) begin
                step();
                check("rally_state", 32'(state), 32'(S_RALLY));
                check("rally_serve_en", 32'(serveEn), 32'd0);
                pulse_hit();
                if (i == 0) begin
                    pulse_toss();
                    check("toss_ignored_in_rally", 32'(state), 32'(S_RALLY));
                end
            end
            wait_tick();
        end

        // Left miss, pause, and a fresh serve back at the base period
        ivl_q.push_back(8);
        step();
        nL = 8'h7F;
        wait_tick();
        ivl_q.push_back(8);
        step();
        nL = 8'hFF;
        push_point(4'd0, 4'd1, 1'b1, S_PAUSE);
        wait_tick();
        ivl_q.push_back(8);
        step();
        check("point_state", 32'(state), 32'(S_POINT));
        step();
        check("pause_serve_en", 32'(serveEn), 32'd0);
        wait_tick();
        ivl_q.push_back(8);
        step();
        check("pause_after_one_tick", 32'(state), 32'(S_PAUSE));
        wait_tick();
        ivl_q.push_back(8);
        step();
        check("serve_after_pause", 32'(state), 32'(S_SERVE));

        // Hit coincident with moveBall
        nL = 8'hFE;
        pulse_toss();
        wait_tick();
        ivl_q.push_back(16);
        step();
        check("rally_again", 32'(state), 32'(S_RALLY));
        wait_tick();
        hit = 1'b1;
        ivl_q.push_back(16);
        ivl_q.push_back(12);
        step();
        hit = 1'b0;
        wait_tick();
        wait_tick();

        // Right player wins the game
        step();
        finish_point(1'b1, 4'd0, 4'd2, 1'b0, S_PAUSE);
        wait_state(S_SERVE);
        play_point(1'b1, 4'd0, 4'd3, 1'b1, S_GAMEOVER);
        check("game_over_flag", 32'(gameOver), 32'd1);
        check("game_over_serve_en", 32'(serveEn), 32'd0);
        wait_tick();
        wait_tick();
        step();
        check("frozen_scoreR", 32'(scoreR), 32'd3);
        check("frozen_state", 32'(state), 32'(S_GAMEOVER));
        pulse_toss();
        check("restart_state", 32'(state), 32'(S_SERVE));
        check("restart_scores", 32'({scoreL, scoreR, server, gameOver}), 32'd0);
        wait_tick();
        step();
        check("no_ball_from_restart_toss", 32'(state), 32'(S_SERVE));

        // Mid-rally asynchronous reset with scoreL=2
        play_point(1'b0, 4'd1, 4'd0, 1'b1, S_PAUSE);
        play_point(1'b0, 4'd2, 4'd0, 1'b0, S_PAUSE);
        nL = 8'hFE;
        wait_tick();
        step();
        check("pre_reset_rally", 32'(state), 32'(S_RALLY));
        check("pre_reset_scoreL", 32'(scoreL), 32'd2);
        nRESET = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_scores", 32'({scoreL, scoreR}), 32'd0);
        check("async_rst_flags", 32'({moveBall, serveEn, server, gameOver}), 32'd0);
        nL = 8'hFF;
        step();
        nRESET = 1'b1;
        step();
        check("post_reset_serve", 32'(state), 32'(S_SERVE));

        check("interval_queue_drained", ivl_q.size(), 32'd0);
        check("point_queue_drained", score_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
